// File: rtl/booth_mul_seq.sv
// ---------------------------------------------------------------------------
// booth_mul_seq
//   Sequential signed 32x32 -> 64-bit multiplier, radix-2 Booth recoding.
//   One Booth step per clock through a 32-bit ripple adder (adder_32_bit).
//   A 33-bit partial accumulator keeps M = 0x80000000 exact.
//   One operation in flight, with a start/busy/done handshake.
//
// Optional feature macro: ZERO_SKIP_EN
//   Defined   : a zero operand at accept goes straight to DONE with hi=lo=0.
//               done rises the cycle after the accepting edge, and busy is
//               never asserted for that operation.
//   Undefined : zero operands run the full 32 iterations.
//
// Ports (booth_mul_seq)
//   clk          in   rising-edge clock
//   clr          in   asynchronous active-high reset
//   start        in   request; sampled only in IDLE or DONE
//   multiplicand in   M, two's complement, captured on an accepted start
//   multiplier   in   Q, two's complement, captured on an accepted start
//   busy         out  high while running iterations
//   done         out  one-cycle pulse; hi/lo valid from this cycle on
//   hi / lo      out  product[63:32] / product[31:0]; held until the next
//                     completion or clr
//
// Ports (adder_32_bit)
//   a, b, cin    in   addends and carry-in
//   sum, cout    out  32-bit sum and carry-out
// ---------------------------------------------------------------------------

module adder_32_bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    logic [32:0] carry;

    assign carry[0] = cin;

    // Plain ripple-carry chain
    for (genvar gi = 0; gi < 32; gi++) begin : g_fa
        assign sum[gi]       = a[gi] ^ b[gi] ^ carry[gi];
        assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
    end

    assign cout = carry[32];
endmodule

module booth_mul_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH-1:0] qr_q, qr_d;
    logic             q1_q, q1_d;
    logic [WIDTH-1:0] mr_q, mr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] b_op;
    logic             cin_op;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic [WIDTH:0]   a_sum;
    logic [WIDTH:0]   a_shift;
    logic [WIDTH-1:0] qr_shift;
    logic             zero_op;

    // Booth recoding of {Qr[0], q_1}: 01 adds M, 10 subtracts M (~M + 1)
    always_comb begin
        b_op   = '0;
        cin_op = 1'b0;
        case ({qr_q[0], q1_q})
            2'b01: begin
                b_op   = mr_q;
                cin_op = 1'b0;
            end
            2'b10: begin
                b_op   = ~mr_q;
                cin_op = 1'b1;
            end
            default: begin
                b_op   = '0;
                cin_op = 1'b0;
            end
        endcase
    end

    adder_32_bit u_adder (
        .a   (a_q[WIDTH-1:0]),
        .b   (b_op),
        .cin (cin_op),
        .sum (add_sum),
        .cout(add_cout)
    );

    // Bit 32 of the 33-bit sum: A[32] + sign-extension of b + carry out of
    // the low 32 bits, all modulo 2.
    assign a_sum    = {a_q[WIDTH] ^ b_op[WIDTH-1] ^ add_cout, add_sum};

    // Arithmetic right shift of {A, Qr, q_1}
    assign a_shift  = {a_sum[WIDTH], a_sum[WIDTH:1]};
    assign qr_shift = {a_sum[0], qr_q[WIDTH-1:1]};

    assign zero_op  = (multiplicand == '0) || (multiplier == '0);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        qr_d    = qr_q;
        q1_d    = q1_q;
        mr_d    = mr_q;
        count_d = count_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_d     = '0;
                    qr_d    = multiplier;
                    q1_d    = 1'b0;
                    mr_d    = multiplicand;
                    count_d = '0;
`ifdef ZERO_SKIP_EN
                    if (zero_op) begin
                        state_d = S_DONE;
                        hi_d    = '0;
                        lo_d    = '0;
                    end else begin
                        state_d = S_RUN;
                    end
`else
                    state_d = S_RUN;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                a_d     = a_shift;
                qr_d    = qr_shift;
                q1_d    = qr_q[0];
                count_d = count_q + CNT_W'(1);
                if (count_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_DONE;
                    hi_d    = a_shift[WIDTH-1:0];
                    lo_d    = qr_shift;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // zero_op only steers the next state when zero skipping is built in
    logic unused_zero;
`ifdef ZERO_SKIP_EN
    assign unused_zero = 1'b0;
`else
    assign unused_zero = zero_op;
`endif

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            qr_q    <= '0;
            q1_q    <= 1'b0;
            mr_q    <= '0;
            count_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            qr_q    <= qr_d;
            q1_q    <= q1_d;
            mr_q    <= mr_d;
            count_q <= count_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: tb/tb_booth_mul_seq.sv
module tb_booth_mul_seq;
    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        start = 1'b0;
    logic [31:0] multiplicand = '0;
    logic [31:0] multiplier = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int busy_len = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
        int          busy_len;
        string       name;
    } exp_t;

    exp_t sb[$];

    booth_mul_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clk         (clk),
        .clr         (clr),
        .start       (start),
        .multiplicand(multiplicand),
        .multiplier  (multiplier),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, expv);
        end else begin
            $display("ok   %s: 0x%016h", name, act);
        end
    endtask

    // Scoreboard monitor: samples on the falling edge
    always @(negedge clk) begin
        if (clr) begin
            busy_len = 0;
        end else begin
            if (busy) busy_len++;
            if (done) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done=1 at cycle %0d expected none", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk({e.name, "_hi"}, {32'b0, hi}, {32'b0, e.hi});
                    chk({e.name, "_lo"}, {32'b0, lo}, {32'b0, e.lo});
                    chk({e.name, "_done_cycle"}, 64'(cyc), 64'(e.cyc));
                    chk({e.name, "_busy_cycles"}, 64'(busy_len), 64'(e.busy_len));
                end
                busy_len = 0;
            end
        end
    end

    // Issue one operation; the accepting edge is the next rising edge
    task automatic issue(input string name, input logic [31:0] m, input logic [31:0] q,
                         input logic [31:0] ehi, input logic [31:0] elo, input bit hold);
        exp_t e;
        int lat;
        lat = 32;
`ifdef ZERO_SKIP_EN
        if (m == 0 || q == 0) lat = 0;
`endif
        @(negedge clk);
        start = 1'b1;
        multiplicand = m;
        multiplier = q;
        @(posedge clk);
        #1;
        e.hi = ehi;
        e.lo = elo;
        e.cyc = cyc + lat;
        e.busy_len = lat;
        e.name = name;
        sb.push_back(e);
        if (!hold) start = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL %s_timeout: got %0d pending results expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_busy", {63'b0, busy}, 64'd0);
        chk("reset_done", {63'b0, done}, 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);
        clr = 1'b0;
        repeat (2) @(negedge clk);

        issue("7x3", 32'd7, 32'd3, 32'h0, 32'h15, 1'b0);
        wait_drain("7x3");
        issue("m5x6", 32'hFFFF_FFFB, 32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFE2, 1'b0);
        wait_drain("m5x6");
        issue("min_x_min", 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0);
        wait_drain("min_x_min");
        issue("min_x_m1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
        wait_drain("min_x_m1");
        issue("max_x_max", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 1'b0);
        wait_drain("max_x_max");
        issue("m7x9", 32'hFFFF_FFF9, 32'd9, 32'hFFFF_FFFF, 32'hFFFF_FFC1, 1'b0);
        wait_drain("m7x9");

        // start with new operands mid-run must be ignored
        issue("ign_12x12", 32'd12, 32'd12, 32'h0, 32'h90, 1'b0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        multiplicand = 32'd99;
        multiplier = 32'd99;
        @(negedge clk);
        start = 1'b0;
        wait_drain("ign_12x12");

        // clr mid-run aborts with no done pulse
        issue("abort_12x12", 32'd12, 32'd12, 32'h0, 32'h90, 1'b0);
        repeat (10) @(posedge clk);
        #2;
        sb.delete();
        clr = 1'b1;
        @(negedge clk);
        #1;
        chk("abort_busy", {63'b0, busy}, 64'd0);
        chk("abort_done", {63'b0, done}, 64'd0);
        chk("abort_hilo", {hi, lo}, 64'd0);
        @(posedge clk);
        #2;
        clr = 1'b0;
        repeat (40) @(negedge clk);
        issue("after_abort_12x12", 32'd12, 32'd12, 32'h0, 32'h90, 1'b0);
        wait_drain("after_abort");

        // zero operand
        issue("zero_x_1234", 32'd0, 32'h1234, 32'h0, 32'h0, 1'b0);
        wait_drain("zero_x_1234");

        // back-to-back with start held high through DONE
        issue("b2b_first", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 1'b1);
        @(negedge clk);
        multiplicand = 32'h1234_5678;
        multiplier = 32'h10;
        repeat (33) @(posedge clk);
        #1;
        begin
            exp_t e;
            e.hi = 32'h1;
            e.lo = 32'h2345_6780;
            e.cyc = cyc + 32;
            e.busy_len = 32;
            e.name = "b2b_second";
            sb.push_back(e);
        end
        start = 1'b0;
        wait_drain("b2b");

        // no stray done afterwards
        repeat (40) @(negedge clk);
        chk("final_queue_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
